// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory write path: MEM geometry and
// the posted-write buffer drain FSM states.
package mem_pkg;
  localparam int MEM_AW = 5;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {IDLE, DRAIN, PAUSE} wb_state_e;
endpackage

// File: rtl/wb_fifo_core.sv
// Storage, pointers, occupancy and per-entry valid bits for the write buffer.
// Entries are exposed whole so the top level can run the forwarding scan.
module wb_fifo_core
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = MEM_AW,
  parameter  int DW    = MEM_DW,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_ovr,
  input  logic [AW-1:0]              i_dir,
  input  logic [DW-1:0]              i_din,
  output logic [CW-1:0]              o_count,
  output logic [PW-1:0]              o_tail,
  output logic [DEPTH-1:0]           o_vld,
  output logic [DEPTH-1:0][AW-1:0]   o_dir,
  output logic [DEPTH-1:0][DW-1:0]   o_din,
  output logic [AW-1:0]              o_head_dir,
  output logic [DW-1:0]              o_head_din
);
  logic [PW-1:0]             r_head, r_tail;
  logic [CW-1:0]             r_count;
  logic [DEPTH-1:0]          r_vld;
  logic [DEPTH-1:0][AW-1:0]  r_dir;
  logic [DEPTH-1:0][DW-1:0]  r_din;
  logic [PW-1:0]             w_newest;

  assign w_newest = r_tail - PW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (i_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Payload needs no reset: the valid bits gate every consumer.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_dir[r_tail] <= i_dir;
      r_din[r_tail] <= i_din;
    end
    if (i_ovr) r_din[w_newest] <= i_din;
  end

  assign o_count    = r_count;
  assign o_tail     = r_tail;
  assign o_vld      = r_vld;
  assign o_dir      = r_dir;
  assign o_din      = r_din;
  assign o_head_dir = r_dir[r_head];
  assign o_head_din = r_din[r_head];
endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer in front of the 32x32 data memory, with read forwarding.
// Optional MEM_WRITE_BUFFER_COALESCE_EN merges a push into the newest entry on address match.
module mem_write_buffer
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = MEM_AW,
  parameter  int DW    = MEM_DW,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_dir,
  input  logic [DW-1:0] in_din,
  input  logic          drain_en,
  output logic          Ewr,
  output logic [AW-1:0] Dir,
  output logic [DW-1:0] Din,
  input  logic [AW-1:0] rd_dir,
  output logic          rd_hit,
  output logic [DW-1:0] rd_data,
  output logic [CW-1:0] count
);
  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  wb_state_e                r_state, w_state_nxt;
  logic                     w_push, w_alloc, w_ovr, w_pop, w_coal;
  logic [PW-1:0]            w_tail, w_k;
  logic [DEPTH-1:0]         w_vld;
  logic [DEPTH-1:0][AW-1:0] w_dir;
  logic [DEPTH-1:0][DW-1:0] w_din;
  logic [AW-1:0]            w_head_dir;
  logic [DW-1:0]            w_head_din;

  wb_fifo_core #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_alloc),
    .i_pop     (w_pop),
    .i_ovr     (w_ovr),
    .i_dir     (in_dir),
    .i_din     (in_din),
    .o_count   (count),
    .o_tail    (w_tail),
    .o_vld     (w_vld),
    .o_dir     (w_dir),
    .o_din     (w_din),
    .o_head_dir(w_head_dir),
    .o_head_din(w_head_din)
  );

  assign w_pop = (r_state == DRAIN) && drain_en;

`ifdef MEM_WRITE_BUFFER_COALESCE_EN
  // Merging into an entry that leaves this cycle would lose the data.
  logic [AW-1:0] w_new_dir;
  assign w_new_dir = w_dir[w_tail - PW'(1)];
  assign w_coal    = (count != '0) && (w_new_dir == in_dir) &&
                     !(w_pop && (count == CW'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign in_ready = (count < FULL) || w_coal;
  assign w_push   = in_valid && in_ready;
  assign w_alloc  = w_push && !w_coal;
  assign w_ovr    = w_push && w_coal;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_push) w_state_nxt = DRAIN;
      DRAIN:   if (!drain_en)                        w_state_nxt = PAUSE;
               else if (count == CW'(1) && !w_push)  w_state_nxt = IDLE;
      PAUSE:   if (drain_en) w_state_nxt = DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Ewr <= 1'b0;
      Dir <= '0;
      Din <= '0;
    end else begin
      Ewr <= w_pop;
      if (w_pop) begin
        Dir <= w_head_dir;
        Din <= w_head_din;
      end
    end
  end

  // Newest-first scan; i == DEPTH lands on the oldest slot when full.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    w_k     = '0;
    for (int i = 1; i <= DEPTH; i++) begin
      w_k = w_tail - PW'(i);
      if (!rd_hit && w_vld[w_k] && (w_dir[w_k] == rd_dir)) begin
        rd_hit  = 1'b1;
        rd_data = w_din[w_k];
      end
    end
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed bench for mem_write_buffer: drain order, full/pause, forwarding,
// simultaneous push/pop with wrap, and reset mid-drain.
module tb_mem_write_buffer;
  import mem_pkg::*;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, drain_en, Ewr, rd_hit;
  logic [AW-1:0] in_dir, Dir, rd_dir;
  logic [DW-1:0] in_din, Din, rd_data;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [AW-1:0] log_dir[$];
  logic [DW-1:0] log_din[$];
  int            log_cyc[$];

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dir(in_dir), .in_din(in_din), .drain_en(drain_en),
    .Ewr(Ewr), .Dir(Dir), .Din(Din),
    .rd_dir(rd_dir), .rd_hit(rd_hit), .rd_data(rd_data), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (Ewr === 1'b1) begin
    log_dir.push_back(Dir); log_din.push_back(Din); log_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1; in_dir = a; in_din = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_dir.delete(); log_din.delete(); log_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; drain_en = 1'b0; in_dir = '0; in_din = '0; rd_dir = '0;
    tick(); tick();
    rst_n = 1'b1; #1;
    checks++; if (Ewr !== 1'b0)   begin failures++; $display("FAIL rst_ewr got=%0h exp=0", Ewr); end
    checks++; if (Dir !== '0)     begin failures++; $display("FAIL rst_dir got=%0h exp=0", Dir); end
    checks++; if (Din !== '0)     begin failures++; $display("FAIL rst_din got=%0h exp=0", Din); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
    checks++; if (rd_hit !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL rst_fwd got=%0h/%0h exp=0/0", rd_hit, rd_data); end
  endtask

  task automatic test_drain_basic();
    logic [AW-1:0] ed[3];
    logic [DW-1:0] ev[3];
    ed = '{5'd2, 5'd1, 5'd3};
    ev = '{32'd11, 32'd13, 32'd12};
    clear_log();
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) push(ed[i], ev[i]);
    repeat (4) tick();
    checks++; if (log_dir.size() != 3) begin failures++; $display("FAIL basic_nwr got=%0d exp=3", log_dir.size()); end
    for (int i = 0; i < 3 && i < log_dir.size(); i++) begin
      checks++;
      if (log_dir[i] !== ed[i] || log_din[i] !== ev[i]) begin
        failures++; $display("FAIL basic_wr%0d got=%0d/%0d exp=%0d/%0d", i, log_dir[i], log_din[i], ed[i], ev[i]);
      end
    end
    if (log_cyc.size() == 3) begin
      checks++;
      if (log_cyc[1] != log_cyc[0] + 1 || log_cyc[2] != log_cyc[1] + 1) begin
        failures++; $display("FAIL basic_consec got=%0d,%0d,%0d exp=consecutive", log_cyc[0], log_cyc[1], log_cyc[2]);
      end
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL basic_count got=%0d exp=0", count); end
    checks++; if (dut.r_state !== IDLE) begin failures++; $display("FAIL basic_state got=%0d exp=%0d", dut.r_state, IDLE); end
  endtask

  task automatic test_full_pause();
    clear_log();
    drain_en = 1'b0;
    push(5'd6, 32'd120); push(5'd7, 32'd56); push(5'd8, 32'd1); push(5'd9, 32'd2);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%0h exp=0", in_ready); end
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
    push(5'd10, 32'd77);
    checks++; if (count !== 3'd4)    begin failures++; $display("FAIL full_nopush got=%0d exp=4", count); end
    checks++; if (log_dir.size() != 0) begin failures++; $display("FAIL full_noewr got=%0d exp=0", log_dir.size()); end
    drain_en = 1'b1;
    tick();
    checks++; if (Ewr !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL resume_gap got=%0h/%0h exp=0/0", Ewr, in_ready); end
    tick();
    checks++; if (Ewr !== 1'b1 || Dir !== 5'd6 || Din !== 32'd120) begin failures++; $display("FAIL resume_first got=%0h %0d/%0d exp=1 6/120", Ewr, Dir, Din); end
    checks++; if (in_ready !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL resume_ready got=%0h/%0d exp=1/3", in_ready, count); end
    repeat (4) tick();
    checks++;
    if (log_dir.size() != 4) begin failures++; $display("FAIL full_nwr got=%0d exp=4", log_dir.size()); end
    else if (log_dir[1] !== 5'd7 || log_din[1] !== 32'd56 || log_dir[2] !== 5'd8 || log_din[2] !== 32'd1 ||
             log_dir[3] !== 5'd9 || log_din[3] !== 32'd2) begin
      failures++; $display("FAIL full_order got=%0d/%0d %0d/%0d %0d/%0d exp=7/56 8/1 9/2",
                           log_dir[1], log_din[1], log_dir[2], log_din[2], log_dir[3], log_din[3]);
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", count); end
  endtask

  task automatic test_forward();
    clear_log();
    drain_en = 1'b0;
    push(5'd6, 32'd120); push(5'd6, 32'd99);
    rd_dir = 5'd6; #1;
    checks++; if (rd_hit !== 1'b1 || rd_data !== 32'd99) begin failures++; $display("FAIL fwd_newest got=%0h/%0d exp=1/99", rd_hit, rd_data); end
    rd_dir = 5'd5; #1;
    checks++; if (rd_hit !== 1'b0 || rd_data !== '0) begin failures++; $display("FAIL fwd_miss got=%0h/%0d exp=0/0", rd_hit, rd_data); end
    rd_dir = 5'd6;
`ifdef MEM_WRITE_BUFFER_COALESCE_EN
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL coal_count got=%0d exp=1", count); end
    drain_en = 1'b1;
    tick(); tick();
    checks++; if (Ewr !== 1'b1 || Dir !== 5'd6 || Din !== 32'd99) begin failures++; $display("FAIL coal_wr got=%0h %0d/%0d exp=1 6/99", Ewr, Dir, Din); end
    checks++; if (rd_hit !== 1'b0) begin failures++; $display("FAIL fwd_popped got=%0h exp=0", rd_hit); end
    repeat (3) tick();
    checks++; if (log_dir.size() != 1) begin failures++; $display("FAIL coal_nwr got=%0d exp=1", log_dir.size()); end
`else
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL dup_count got=%0d exp=2", count); end
    drain_en = 1'b1;
    tick(); tick();
    checks++; if (Ewr !== 1'b1 || Dir !== 5'd6 || Din !== 32'd120) begin failures++; $display("FAIL dup_wr0 got=%0h %0d/%0d exp=1 6/120", Ewr, Dir, Din); end
    checks++; if (rd_hit !== 1'b1 || rd_data !== 32'd99) begin failures++; $display("FAIL fwd_remain got=%0h/%0d exp=1/99", rd_hit, rd_data); end
    tick();
    checks++; if (Ewr !== 1'b1 || Dir !== 5'd6 || Din !== 32'd99) begin failures++; $display("FAIL dup_wr1 got=%0h %0d/%0d exp=1 6/99", Ewr, Dir, Din); end
    checks++; if (rd_hit !== 1'b0) begin failures++; $display("FAIL fwd_popped got=%0h exp=0", rd_hit); end
    repeat (3) tick();
    checks++; if (log_dir.size() != 2) begin failures++; $display("FAIL dup_nwr got=%0d exp=2", log_dir.size()); end
`endif
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL fwd_empty got=%0d exp=0", count); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    drain_en = 1'b0;
    push(5'd1, 32'd101); push(5'd2, 32'd102);
    drain_en = 1'b1;
    tick();
    for (int i = 3; i <= 6; i++) begin
      push(5'(i), 32'(100 + i));
      checks++;
      if (count !== 3'd2 || Ewr !== 1'b1) begin
        failures++; $display("FAIL b2b_count%0d got=%0d ewr=%0h exp=2 ewr=1", i, count, Ewr);
      end
    end
    repeat (4) tick();
    checks++;
    if (log_dir.size() != 6) begin failures++; $display("FAIL b2b_nwr got=%0d exp=6", log_dir.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++;
      if (log_dir[i] !== 5'(i + 1) || log_din[i] !== 32'(101 + i)) begin
        failures++; $display("FAIL b2b_wr%0d got=%0d/%0d exp=%0d/%0d", i, log_dir[i], log_din[i], i + 1, 101 + i);
      end
    end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid_drain();
    drain_en = 1'b0;
    push(5'd20, 32'd1); push(5'd21, 32'd2); push(5'd22, 32'd3); push(5'd23, 32'd4);
    drain_en = 1'b1;
    tick(); tick();
    checks++; if (Ewr !== 1'b1 || count !== 3'd3) begin failures++; $display("FAIL mid_pre got=%0h/%0d exp=1/3", Ewr, count); end
    rst_n = 1'b0; rd_dir = 5'd21;
    tick();
    checks++; if (Ewr !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL mid_rst got=%0h/%0d exp=0/0", Ewr, count); end
    checks++; if (rd_hit !== 1'b0) begin failures++; $display("FAIL mid_fwd got=%0h exp=0", rd_hit); end
    rst_n = 1'b1;
    tick();
    checks++; if (Ewr !== 1'b0 || Dir !== '0 || Din !== '0) begin failures++; $display("FAIL mid_post got=%0h %0d/%0d exp=0 0/0", Ewr, Dir, Din); end
  endtask

  initial begin
    test_reset();
    test_drain_basic();
    test_full_pause();
    test_forward();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer directly upstream of the 32x32 data memory (MEM: Din, Dir, Ewr, Dout).
- Accepts write requests from the execute stage over a valid/ready handshake and queues them in a FIFO.
- Drains the queue to MEM at one write per cycle through registered Din/Dir/Ewr.
- Provides a combinational read-forwarding lookup so reads of addresses that are still queued return the newest pending data.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- AW, 5, address width; matches MEM Dir.
- DW, 32, data width; matches MEM Din.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  write request present.
- in_ready  out  1  buffer can accept; equals (count < DEPTH).
- in_dir  in  AW  write address.
- in_din  in  DW  write data.
- drain_en  in  1  permits a pop toward MEM this cycle.
- Ewr  out  1  registered write enable to MEM.
- Dir  out  AW  registered address to MEM.
- Din  out  DW  registered data to MEM.
- rd_dir  in  AW  forwarding lookup address.
- rd_hit  out  1  some valid entry matches rd_dir (combinational).
- rd_data  out  DW  data of the newest matching entry; 0 when no hit.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - head=tail=count=0, all entry valid bits cleared, state=IDLE.
  - Ewr=0, Dir=0, Din=0.
  - Reset mid-drain discards all queued entries; no write is issued on the next cycle.
- Push: in_valid && in_ready at an edge writes the entry at tail, then tail=tail+1 mod DEPTH.
  - No push when full, even if a pop happens the same cycle; in_ready does not depend on drain_en.
- Pop: when state=DRAIN and drain_en=1, the head entry is loaded into Dir/Din with Ewr=1 at the edge, then head=head+1 mod DEPTH.
  - In every other cycle Ewr=0 at the edge; Dir/Din hold their values.
- Latency: a push into an empty buffer at edge N with drain_en high produces Ewr=1 after edge N+1. No same-cycle bypass.
- Simultaneous push and pop: both take effect; count is unchanged.
- Ordering: strict FIFO; writes to MEM leave in acceptance order.
- FSM (registered):
  - IDLE: count=0. Go to DRAIN when a push occurs.
  - DRAIN: count>0 and drain_en sampled high. Go to PAUSE when drain_en=0 and count>0. Go to IDLE when the last entry pops with no push.
  - PAUSE: count>0 and drain_en low. Go to DRAIN when drain_en=1; the first pop happens on the next edge.
- Forwarding:
  - Scan entries from tail-1 back toward head; the first valid entry with dir==rd_dir wins.
  - The entry currently presented on Dir/Din (already popped) is not searched.
  - Purely combinational; reflects pre-edge state.
- Wrap-around: pointers are AW-independent, $clog2(DEPTH) bits wide. count ranges 0..DEPTH.

Optional Feature:
- Macro: MEM_WRITE_BUFFER_COALESCE_EN.
- Defined: a push whose in_dir equals the newest valid entry's address overwrites that entry's data in place.
  - tail and count do not change.
  - in_ready stays 1 in that case even when full.
  - Exception: if that newest entry is being popped in the same cycle, the push allocates normally.
- Not defined: every push allocates a new entry; duplicate addresses are written to MEM in order.

Decomposition:
- Package mem_pkg holds: the state enum (IDLE, DRAIN, PAUSE), and the AW/DW default constants shared with MEM.
- One natural sub-module: wb_fifo_core, containing storage, pointers, count and valid bits.
- The top level keeps the FSM, output registers, forwarding mux and coalesce logic.

Test Plan:
- Reset, then push (2,11), (1,13), (3,12) with drain_en=1 -> Ewr pulses on 3 consecutive cycles carrying Dir/Din = 2/11, 1/13, 3/12; count returns to 0; state returns to IDLE.
- drain_en=0, push 4 entries (6,120), (7,56), (8,1), (9,2) -> in_ready=0, count=4, Ewr stays 0; raise drain_en -> the 4 writes appear in order and in_ready rises after the first pop.
- Queue (6,120) then (6,99) with drain_en=0, rd_dir=6 -> rd_hit=1, rd_data=99; rd_dir=5 -> rd_hit=0, rd_data=0.
- Buffer holding 2 entries, drain_en=1, push in the same cycle -> count unchanged; 6 pushes in total exercise pointer wrap with no loss or reordering.
- Reset asserted while 3 entries are queued -> on the next cycle Ewr=0, count=0, rd_hit=0.
- With MEM_WRITE_BUFFER_COALESCE_EN defined: push (6,120) then (6,56) while paused -> count=1; on drain, a single write 6/56.
